// File: rtl/tenyr_pkg.sv
// tenyr_pkg
// Shared definitions for the handshaked tenyr core:
//   - instruction field bit positions
//   - opcode values
//   - FSM state encoding
//   - the all-ones illegal instruction word
//   - an immediate sign-extension helper
// Optional build macro affecting users of this package: TENYR_MUL_EN
// (enables op 3 as a multiply inside tenyr_alu).
package tenyr_pkg;

    // Instruction field positions
    localparam int TYPE_BIT  = 30;
    localparam int STORE_BIT = 29;
    localparam int DEREF_BIT = 28;
    localparam int Z_LSB     = 24;
    localparam int X_LSB     = 20;
    localparam int Y_LSB     = 16;
    localparam int OP_LSB    = 12;
    localparam int IMM_W     = 12;

    // Opcodes
    localparam logic [3:0] OP_OR    = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_RSV4  = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_LT    = 4'd6;
    localparam logic [3:0] OP_EQ    = 4'd7;
    localparam logic [3:0] OP_GT    = 4'd8;
    localparam logic [3:0] OP_ANDN  = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_SUB   = 4'd11;
    localparam logic [3:0] OP_XNOR  = 4'd12;
    localparam logic [3:0] OP_SHR   = 4'd13;
    localparam logic [3:0] OP_NE    = 4'd14;
    localparam logic [3:0] OP_RSV15 = 4'd15;

    // Register indices with special read/write behaviour
    localparam logic [3:0] REG_ZERO = 4'd0;
    localparam logic [3:0] REG_PC   = 4'd15;

    localparam logic [31:0] ILLEGAL_INSN = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM    = 3'd2,
        COMMIT = 3'd3,
        HALT   = 3'd4
    } state_t;

    function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/tenyr_alu.sv
// tenyr_alu
// Combinational tenyr ALU: rhs = (x op y) + a, all 32-bit wrap.
// The core chooses operand order by instruction type (y/a swap).
// Ports:
//   op       in  4   opcode
//   x, y, a  in  32  operands (a is the added term)
//   rhs      out 32  result
//   reserved out 1   opcode is reserved (the core traps on it)
// Build macro TENYR_MUL_EN: when defined op 3 is a low-half multiply,
// otherwise op 3 is reserved and no multiplier exists.
import tenyr_pkg::*;

module tenyr_alu (
    input  logic [3:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] a,
    output logic [31:0] rhs,
    output logic        reserved
);

    logic [31:0] res;
    logic        shift_big;

    // Any set bit above bit 4 means a shift of 32 or more, which clears.
    assign shift_big = |y[31:5];

    always_comb begin
        res      = '0;
        reserved = 1'b0;
        case (op)
            OP_OR:   res = x | y;
            OP_AND:  res = x & y;
            OP_ADD:  res = x + y;
`ifdef TENYR_MUL_EN
            // Low 32 bits are identical for signed and unsigned products.
            OP_MUL:  res = x * y;
`else
            OP_MUL:  reserved = 1'b1;
`endif
            OP_SHL:  res = shift_big ? 32'd0 : (x << y[4:0]);
            OP_LT:   res = ($signed(x) <  $signed(y)) ? 32'hFFFF_FFFF : 32'd0;
            OP_EQ:   res = (x == y)                   ? 32'hFFFF_FFFF : 32'd0;
            OP_GT:   res = ($signed(x) >  $signed(y)) ? 32'hFFFF_FFFF : 32'd0;
            OP_ANDN: res = x & ~y;
            OP_XOR:  res = x ^ y;
            OP_SUB:  res = x - y;
            OP_XNOR: res = ~(x ^ y);
            OP_SHR:  res = shift_big ? 32'd0 : (x >> y[4:0]);
            OP_NE:   res = (x != y)                   ? 32'hFFFF_FFFF : 32'd0;
            default: reserved = 1'b1;
        endcase
        rhs = res + a;
    end

endmodule

// File: rtl/tenyr_core_hs.sv
// tenyr_core_hs
// Multi-cycle tenyr CPU with ready/ack handshakes on the instruction
// and data buses (FETCH -> EXEC -> [MEM] -> COMMIT, HALT on trap or
// on a halt request seen in COMMIT).
// Parameters: RESET_VECTOR (first fetch address), ADDR_W (bus address width).
// Ports:
//   clk, reset_n (sync, active-low), en (clock enable)
//   halt_in / halted             halt request and status
//   i_req, i_addr, i_ack, i_data instruction bus
//   d_req, d_we, d_addr, d_wdata, d_ack, d_rdata  data bus
// Build macro TENYR_MUL_EN (handled in tenyr_alu) enables op 3 multiply.
import tenyr_pkg::*;

module tenyr_core_hs #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
    parameter int          ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              halt_in,
    output logic              halted,
    output logic              i_req,
    output logic [ADDR_W-1:0] i_addr,
    input  logic              i_ack,
    input  logic [31:0]       i_data,
    output logic              d_req,
    output logic              d_we,
    output logic [ADDR_W-1:0] d_addr,
    output logic [31:0]       d_wdata,
    input  logic              d_ack,
    input  logic [31:0]       d_rdata
);

    state_t state, state_next;

    // Cleared by reset so the first fetch request appears one enabled
    // edge after reset release rather than during reset.
    logic armed;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [31:0]       pc_plus1_ext;
    logic [31:0]       insn;
    logic [31:0]       rhs_q;
    logic [31:0]       load_q;
    logic [31:0]       regs [0:15];

    logic        f_type, f_store, f_deref;
    logic [3:0]  z_idx, x_idx, y_idx, op;
    logic [31:0] imm;
    logic [31:0] x_val, y_val, z_val;
    logic [31:0] alu_y, alu_a, alu_rhs;
    logic        alu_reserved;
    logic        illegal, mem_op;
    logic        fetch_done, data_done;
    logic [31:0] wb_val;
    logic        unused_insn_msb;

    assign f_type   = insn[TYPE_BIT];
    assign f_store  = insn[STORE_BIT];
    assign f_deref  = insn[DEREF_BIT];
    assign z_idx    = insn[Z_LSB +: 4];
    assign x_idx    = insn[X_LSB +: 4];
    assign y_idx    = insn[Y_LSB +: 4];
    assign op       = insn[OP_LSB +: 4];
    assign imm      = sext_imm(insn[IMM_W-1:0]);
    assign unused_insn_msb = insn[31];

    assign pc_plus1     = pc + ADDR_W'(1);
    assign pc_plus1_ext = 32'(pc_plus1);
    assign i_addr       = pc;

    // r0 reads zero and r15 reads the address of the next instruction.
    function automatic logic [31:0] read_reg(input logic [3:0]  idx,
                                             input logic [31:0] file_val,
                                             input logic [31:0] p_val);
        if (idx == REG_ZERO)
            return 32'd0;
        else if (idx == REG_PC)
            return p_val;
        else
            return file_val;
    endfunction

    assign x_val = read_reg(x_idx, regs[x_idx], pc_plus1_ext);
    assign y_val = read_reg(y_idx, regs[y_idx], pc_plus1_ext);
    assign z_val = read_reg(z_idx, regs[z_idx], pc_plus1_ext);

    // Type 1 swaps the roles of Y and the immediate: (X op I) + Y.
    assign alu_y = f_type ? imm   : y_val;
    assign alu_a = f_type ? y_val : imm;

    tenyr_alu u_alu (
        .op       (op),
        .x        (x_val),
        .y        (alu_y),
        .a        (alu_a),
        .rhs      (alu_rhs),
        .reserved (alu_reserved)
    );

    assign illegal    = (insn == ILLEGAL_INSN) || alu_reserved;
    assign mem_op     = f_store || f_deref;
    assign fetch_done = i_req && i_ack;
    assign data_done  = d_req && d_ack;
    assign wb_val     = f_deref ? load_q : rhs_q;

    // State register; reset wins over the clock enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
            armed <= 1'b0;
        end else if (en) begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:  if (fetch_done) state_next = EXEC;
            EXEC: begin
                if (illegal)     state_next = HALT;
                else if (mem_op) state_next = MEM;
                else             state_next = COMMIT;
            end
            MEM:    if (data_done) state_next = COMMIT;
            COMMIT: state_next = halt_in ? HALT : FETCH;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Bus request and status outputs decoded from the current state.
    always_comb begin
        i_req  = 1'b0;
        d_req  = 1'b0;
        halted = 1'b0;
        case (state)
            FETCH:   i_req  = armed;
            MEM:     d_req  = 1'b1;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath: instruction latch, rhs register, data bus registers,
    // load data latch, register file and PC. All frozen when en is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc      <= RESET_VECTOR[ADDR_W-1:0];
            insn    <= '0;
            rhs_q   <= '0;
            load_q  <= '0;
            d_we    <= 1'b0;
            d_addr  <= '0;
            d_wdata <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (en) begin
            case (state)
                FETCH: begin
                    if (fetch_done) insn <= i_data;
                end
                EXEC: begin
                    rhs_q <= alu_rhs;
                    if (!illegal && mem_op) begin
                        d_we <= f_store;
                        // store-without-deref writes rhs to address Z;
                        // the other memory forms address memory by rhs.
                        if (f_store && !f_deref) begin
                            d_addr  <= z_val[ADDR_W-1:0];
                            d_wdata <= alu_rhs;
                        end else begin
                            d_addr  <= alu_rhs[ADDR_W-1:0];
                            d_wdata <= z_val;
                        end
                    end
                end
                MEM: begin
                    if (data_done) load_q <= d_rdata;
                end
                COMMIT: begin
                    if (!f_store && z_idx != REG_ZERO && z_idx != REG_PC)
                        regs[z_idx] <= wb_val;
                    if (!f_store && z_idx == REG_PC)
                        pc <= wb_val[ADDR_W-1:0];
                    else
                        pc <= pc_plus1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tenyr_core_hs.sv
// tb_tenyr_core_hs
// Directed bench for tenyr_core_hs: reset state, handshake latencies
// with wait states, store/load/branch bus values, traps, reset during
// MEM, clock enable freeze and halt request.
module tb_tenyr_core_hs;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        halt_in;
    logic        halted;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_data;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    int tests_run;
    int tests_failed;

    tenyr_core_hs #(
        .RESET_VECTOR (32'h0000_1000),
        .ADDR_W       (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .halt_in (halt_in),
        .halted  (halted),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_data  (i_data),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge, check the reset values, then release.
    task automatic applyReset();
        reset_n = 1'b0;
        en      = 1'b1;
        halt_in = 1'b0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        tick();
        checkOutput("rst_i_req",  32'(i_req),  32'd0);
        checkOutput("rst_d_req",  32'(d_req),  32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_i_addr", i_addr,      32'h0000_1000);
        checkOutput("rst_d_addr", d_addr,      32'd0);
        reset_n = 1'b1;
    endtask

    // Present one instruction after 'waits' idle cycles; cycles counts
    // edges from the first observed request up to the accepting edge.
    task automatic applyStimulus(input logic [31:0] word, input int waits,
                                 output int cycles);
        cycles = 0;
        for (int k = 0; k < waits; k++) begin
            tick();
            cycles++;
        end
        i_data = word;
        i_ack  = 1'b1;
        tick();
        cycles++;
        i_ack  = 1'b0;
        i_data = 32'd0;
    endtask

    task automatic waitIReq(input string tag, output int cycles);
        cycles = 0;
        while (!i_req && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!i_req) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitDReq(input string tag);
        int n;
        n = 0;
        while (!d_req && n < 20) begin
            tick();
            n++;
        end
        if (!d_req) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Acknowledge the data request after 'waits' cycles; held counts
    // cycles the request was observed high.
    task automatic serveData(input int waits, input logic [31:0] rdata,
                             output int held);
        held = 0;
        while (d_req && held < 20) begin
            held++;
            if (held == waits + 1) begin
                d_ack   = 1'b1;
                d_rdata = rdata;
            end
            tick();
            d_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc, cyc2, held;
        tests_run    = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        en      = 1'b1;
        halt_in = 1'b0;
        i_ack   = 1'b0;
        i_data  = 32'd0;
        d_ack   = 1'b0;
        d_rdata = 32'd0;

        // Reset release and first fetch request
        applyReset();
        tick();
        checkOutput("first_i_req",  32'(i_req),  32'd1);
        checkOutput("first_i_addr", i_addr,      32'h0000_1000);
        checkOutput("first_halted", 32'(halted), 32'd0);
        checkOutput("first_d_req",  32'(d_req),  32'd0);

        // r1 = 5 with a two-cycle fetch delay
        applyStimulus(32'h0100_2005, 2, cyc);
        waitIReq("add", cyc2);
        checkOutput("add_latency", 32'(cyc + cyc2), 32'd5);
        checkOutput("add_next_pc", i_addr, 32'h0000_1001);

        // mem[0x100] <= r1 with d_ack three cycles late
        applyStimulus(32'h3100_0100, 0, cyc);
        waitDReq("store");
        checkOutput("store_we",    32'(d_we), 32'd1);
        checkOutput("store_addr",  d_addr,    32'h0000_0100);
        checkOutput("store_wdata", d_wdata,   32'd5);
        serveData(3, 32'd0, held);
        checkOutput("store_held", 32'(held), 32'd4);
        waitIReq("store", cyc2);
        checkOutput("store_next_pc", i_addr, 32'h0000_1002);

        // P <= mem[0x100]
        applyStimulus(32'h1F00_0100, 0, cyc);
        waitDReq("ldbr");
        checkOutput("ldbr_we",   32'(d_we), 32'd0);
        checkOutput("ldbr_addr", d_addr,    32'h0000_0100);
        serveData(0, 32'h0000_2000, held);
        checkOutput("ldbr_held", 32'(held), 32'd1);
        waitIReq("ldbr", cyc2);
        checkOutput("ldbr_target", i_addr, 32'h0000_2000);

        // r1 = r1 * 3
        applyStimulus(32'h4110_3003, 0, cyc);
`ifdef TENYR_MUL_EN
        waitIReq("mul", cyc2);
        checkOutput("mul_next_pc", i_addr, 32'h0000_2001);
        applyStimulus(32'h3100_0100, 0, cyc);
        waitDReq("mul_store");
        checkOutput("mul_result", d_wdata, 32'd15);
        serveData(0, 32'd0, held);
`else
        tick();
        checkOutput("mul_trap_halted", 32'(halted), 32'd1);
        checkOutput("mul_trap_pc",     i_addr,      32'h0000_2000);
        checkOutput("mul_trap_r1",     dut.regs[1], 32'd5);
`endif

        // All-ones word traps; acks while halted do nothing
        applyReset();
        tick();
        applyStimulus(32'hFFFF_FFFF, 0, cyc);
        tick();
        checkOutput("ill_halted", 32'(halted), 32'd1);
        checkOutput("ill_pc",     i_addr,      32'h0000_1000);
        i_ack = 1'b1;
        d_ack = 1'b1;
        tick();
        tick();
        tick();
        i_ack = 1'b0;
        d_ack = 1'b0;
        checkOutput("ill_no_i_req", 32'(i_req),  32'd0);
        checkOutput("ill_no_d_req", 32'(d_req),  32'd0);
        checkOutput("ill_stay",     32'(halted), 32'd1);
        checkOutput("ill_pc_stay",  i_addr,      32'h0000_1000);

        // Reserved op 4 traps
        applyReset();
        tick();
        applyStimulus(32'h0100_4000, 0, cyc);
        tick();
        checkOutput("op4_halted", 32'(halted), 32'd1);
        checkOutput("op4_pc",     i_addr,      32'h0000_1000);

        // Reset pulse while a data request is outstanding
        applyReset();
        tick();
        applyStimulus(32'h3100_0100, 0, cyc);
        waitDReq("rstmem");
        checkOutput("rstmem_d_req_before", 32'(d_req), 32'd1);
        reset_n = 1'b0;
        tick();
        checkOutput("rstmem_d_req", 32'(d_req), 32'd0);
        checkOutput("rstmem_pc",    i_addr,     32'h0000_1000);
        reset_n = 1'b1;

        // Clock enable low: acks ignored, request held
        tick();
        en     = 1'b0;
        i_data = 32'h0100_2005;
        i_ack  = 1'b1;
        tick();
        tick();
        checkOutput("en_hold_i_req", 32'(i_req), 32'd1);
        i_ack = 1'b0;
        en    = 1'b1;
        tick();
        checkOutput("en_still_fetch", 32'(i_req), 32'd1);
        checkOutput("en_pc",          i_addr,     32'h0000_1000);

        // Zero-wait non-memory instruction takes three cycles
        applyStimulus(32'h0100_2005, 0, cyc);
        waitIReq("zw", cyc2);
        checkOutput("zw_latency", 32'(cyc + cyc2), 32'd3);

        // Halt request during an add: it commits, then the core halts
        halt_in = 1'b1;
        applyStimulus(32'h0100_200A, 0, cyc);
        tick();
        tick();
        checkOutput("hreq_halted", 32'(halted), 32'd1);
        checkOutput("hreq_pc",     i_addr,      32'h0000_1002);
        checkOutput("hreq_r1",     dut.regs[1], 32'd10);
        checkOutput("hreq_i_req",  32'(i_req),  32'd0);
        halt_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
